sha256_msg_pad: RTL and testbench

Upstream feeder for the SHA-256 compression core (`H256_in`/`M256_in`/`in_v` → `H256_out`/`out_v`). Accepts a message as a byte stream with a valid/ready handshake and applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length). Emits one 512-bit block at a time, with first/last flags, and holds off until the core signals completion. The first/last flags let downstream chaining logic choose H0 or the previous digest, and know when `H256_out` is final.

---
 rtl/sha256_pkg.sv | 22 ++
 rtl/sha256_lane_wr.sv | 22 ++
 rtl/sha256_msg_pad.sv | 147 ++++++++++++++
 tb/tb_sha256_msg_pad.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder.
//   BLK_BYTES  : bytes per 512-bit block
//   LEN_LANE   : first lane of the 64-bit big-endian length field
//   PAD_MARK   : end-of-message marker byte
//   pad_state_e: padder FSM states
//   ABC_BLOCK  : padded single block for the message "abc"
package sha256_pkg;

   localparam int unsigned BLK_BYTES = 64;
   localparam int unsigned LEN_LANE  = 56;
   localparam logic [7:0]  PAD_MARK  = 8'h80;

   typedef enum logic [1:0] {
      StFill,
      StPad,
      StEmit,
      StWait
   } pad_state_e;

   localparam logic [511:0] ABC_BLOCK = {8'h61, 8'h62, 8'h63, PAD_MARK, 416'h0, 64'h18};

endpackage

// File: rtl/sha256_lane_wr.sv
// Lane mask generator for the 64-byte block register.
//   idx       : current lane index (0..64)
//   wr_mask   : one-hot, bit i set when lane i is the write lane
//   fill_mask : bit i set for every lane at or above idx (zero-fill range)
module sha256_lane_wr
   import sha256_pkg::*;
(
   input  logic [6:0]           idx,
   output logic [BLK_BYTES-1:0] wr_mask,
   output logic [BLK_BYTES-1:0] fill_mask
);

   always_comb begin
      wr_mask   = '0;
      fill_mask = '0;
      for (int i = 0; i < BLK_BYTES; i++) begin
         wr_mask[i]   = (idx == 7'(i));
         fill_mask[i] = (7'(i) >= idx);
      end
   end

endmodule

// File: rtl/sha256_msg_pad.sv
// SHA-256 message padder: collects a byte stream into 512-bit blocks, appends
// the 0x80 marker, zero fill and the 64-bit bit length, and hands one block at
// a time to the compression core.
//   clk, reset  : clock, synchronous active-high reset
//   byte_in/_v  : message byte and its valid
//   msg_end     : end of message (with or without a byte)
//   byte_rdy    : byte / msg_end accepted this cycle
//   M256_out    : padded block, byte 0 in [511:504]
//   blk_v       : one-cycle block valid pulse
//   blk_first   : first block of the message (qualified by blk_v)
//   blk_last    : final block of the message (qualified by blk_v)
//   core_done   : core has consumed the block
module sha256_msg_pad
   import sha256_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   byte_in,
   input  logic         byte_v,
   input  logic         msg_end,
   output logic         byte_rdy,
   output logic [511:0] M256_out,
   output logic         blk_v,
   output logic         blk_first,
   output logic         blk_last,
   input  logic         core_done
);

   pad_state_e  state_q;
   logic [6:0]  idx_q;
   logic [63:0] bitlen_q;
   logic        first_pend_q;
   logic        mark_done_q;
   logic        final_q;
   logic        end_seen_q;

   logic [BLK_BYTES-1:0] wr_mask;
   logic [BLK_BYTES-1:0] fill_mask;
   logic [511:0]         data_blk;
   logic [511:0]         pad_blk;
   logic [6:0]           idx_mark;
   logic                 len_fits;

   sha256_lane_wr u_lane_wr (
      .idx       (idx_q),
      .wr_mask   (wr_mask),
      .fill_mask (fill_mask)
   );

   assign byte_rdy = (state_q == StFill);

   // Candidate block contents for a data write (FILL) and for padding (PAD).
   always_comb begin
      data_blk = M256_out;
      pad_blk  = M256_out;
      idx_mark = idx_q + {6'd0, ~mark_done_q};
      len_fits = (idx_mark <= 7'(LEN_LANE));
      for (int i = 0; i < BLK_BYTES; i++) begin
         if (wr_mask[i]) begin
            data_blk[511-8*i -: 8] = byte_in;
         end
         if (fill_mask[i]) begin
            pad_blk[511-8*i -: 8] = (wr_mask[i] && !mark_done_q) ? PAD_MARK : 8'h00;
         end
      end
      if (len_fits) begin
         pad_blk[63:0] = bitlen_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StFill;
         idx_q        <= '0;
         bitlen_q     <= '0;
         first_pend_q <= 1'b1;
         mark_done_q  <= 1'b0;
         final_q      <= 1'b0;
         end_seen_q   <= 1'b0;
         M256_out     <= '0;
         blk_v        <= 1'b0;
         blk_first    <= 1'b0;
         blk_last     <= 1'b0;
      end else begin
         blk_v     <= 1'b0;
         blk_first <= 1'b0;
         blk_last  <= 1'b0;
         unique case (state_q)
            StFill: begin
               if (byte_v) begin
                  M256_out <= data_blk;
                  idx_q    <= idx_q + 7'd1;
                  bitlen_q <= bitlen_q + 64'd8;
                  if (idx_q == 7'(BLK_BYTES - 1)) begin
                     // Full data block goes out directly; a full block is never final.
                     state_q    <= StEmit;
                     end_seen_q <= msg_end;
                     blk_v      <= 1'b1;
                     blk_first  <= first_pend_q;
                  end else if (msg_end) begin
                     state_q    <= StPad;
                     end_seen_q <= 1'b1;
                  end
               end else if (msg_end) begin
                  state_q    <= StPad;
                  end_seen_q <= 1'b1;
               end
            end
            StPad: begin
               M256_out    <= pad_blk;
               mark_done_q <= 1'b1;
               idx_q       <= idx_mark;
               final_q     <= len_fits;
               state_q     <= StEmit;
               blk_v       <= 1'b1;
               blk_first   <= first_pend_q;
               blk_last    <= len_fits;
            end
            StEmit: begin
               first_pend_q <= 1'b0;
               state_q      <= StWait;
            end
            StWait: begin
               if (core_done) begin
                  idx_q <= '0;
                  if (final_q) begin
                     state_q      <= StFill;
                     bitlen_q     <= '0;
                     first_pend_q <= 1'b1;
                     mark_done_q  <= 1'b0;
                     final_q      <= 1'b0;
                     end_seen_q   <= 1'b0;
                  end else if (end_seen_q) begin
                     // Length did not fit: build the tail block from scratch.
                     M256_out <= '0;
                     state_q  <= StPad;
                  end else begin
                     state_q <= StFill;
                  end
               end
            end
            default: state_q <= StFill;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Bench for sha256_msg_pad: a FIPS 180-4 padding model fills a scoreboard with
// expected blocks; a monitor pops and compares each emitted block.
module tb_sha256_msg_pad;
   import sha256_pkg::*;

   logic         clk;
   logic         reset;
   logic [7:0]   byte_in;
   logic         byte_v;
   logic         msg_end;
   logic         byte_rdy;
   logic [511:0] M256_out;
   logic         blk_v;
   logic         blk_first;
   logic         blk_last;
   logic         core_done;

   typedef struct {
      logic [511:0] blk;
      logic         first;
      logic         last;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] msg[$];
   int         n_pass  = 0;
   int         n_total = 0;
   bit         is_abc  = 1'b0;

   sha256_msg_pad dut (
      .clk       (clk),
      .reset     (reset),
      .byte_in   (byte_in),
      .byte_v    (byte_v),
      .msg_end   (msg_end),
      .byte_rdy  (byte_rdy),
      .M256_out  (M256_out),
      .blk_v     (blk_v),
      .blk_first (blk_first),
      .blk_last  (blk_last),
      .core_done (core_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Scoreboard consumer.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && blk_v) begin
         if (exp_q.size() == 0) begin
            check_eq("extra_blk", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_eq("blk_data", M256_out, e.blk);
            check_eq("blk_first", blk_first, e.first);
            check_eq("blk_last", blk_last, e.last);
         end
      end
   end

   // Reference padding of msg[] into whole blocks.
   task automatic push_expected();
      int         n;
      int         tot;
      logic [63:0] bl;
      logic [7:0] pb[];
      exp_t       e;
      n   = msg.size();
      tot = ((n + 8) / 64 + 1) * 64;
      pb  = new[tot];
      foreach (pb[i]) pb[i] = 8'h00;
      for (int i = 0; i < n; i++) pb[i] = msg[i];
      pb[n] = 8'h80;
      bl = 64'(n) * 64'd8;
      for (int j = 0; j < 8; j++) pb[tot-1-j] = bl[8*j +: 8];
      for (int b = 0; b < tot / 64; b++) begin
         e.blk = '0;
         for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = pb[64*b+i];
         e.first = (b == 0);
         e.last  = (b == tot / 64 - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic send_one(input logic v, input logic [7:0] b, input logic e);
      int n;
      n       = 0;
      byte_v  = v;
      byte_in = b;
      msg_end = e;
      while (!byte_rdy && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!byte_rdy) check_eq("rdy_timeout", 0, 1);
      @(posedge clk);
      #1;
      byte_v  = 1'b0;
      msg_end = 1'b0;
   endtask

   // Core stand-in: acknowledges each block a few cycles after it appears.
   task automatic core_resp(input int nblk, input bit stray);
      int n;
      if (stray) begin
         @(posedge clk);
         #1 core_done = 1'b1;
         @(posedge clk);
         #1 core_done = 1'b0;
         check_eq("stray_rdy", byte_rdy, 1);
         check_eq("stray_blk", blk_v, 0);
      end
      for (int b = 0; b < nblk; b++) begin
         n = 0;
         while (!blk_v && n < 300) begin
            @(posedge clk);
            #1;
            n++;
         end
         if (!blk_v) begin
            check_eq("blk_timeout", 0, 1);
            return;
         end
         if (is_abc) check_eq("abc_vec", M256_out, ABC_BLOCK);
         @(posedge clk);
         #1;
         check_eq("wait_rdy", byte_rdy, 0);
         repeat (2) @(posedge clk);
         #1 core_done = 1'b1;
         @(posedge clk);
         #1 core_done = 1'b0;
      end
   endtask

   // Sends msg[] (msg_end with the last byte, or alone afterwards) and services blocks.
   task automatic run_msg(input bit end_alone, input bit stray);
      int n;
      int nblk;
      int lat_exp;
      n       = msg.size();
      nblk    = (n + 8) / 64 + 1;
      // blk_v follows the accepting edge directly only for a full block ending the message.
      lat_exp = (!end_alone && n % 64 == 0) ? 0 : 1;
      push_expected();
      fork
         begin
            int lat;
            for (int i = 0; i < n; i++) send_one(1'b1, msg[i], !end_alone && (i == n - 1));
            if (end_alone) send_one(1'b0, 8'h00, 1'b1);
            lat = 0;
            while (!blk_v && lat < 10) begin
               @(posedge clk);
               #1;
               lat++;
            end
            check_eq("latency", lat, lat_exp);
         end
         core_resp(nblk, stray);
      join
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic load_abc();
      msg.delete();
      msg.push_back(8'h61);
      msg.push_back(8'h62);
      msg.push_back(8'h63);
   endtask

   initial begin
      reset     = 1'b1;
      byte_in   = 8'h00;
      byte_v    = 1'b0;
      msg_end   = 1'b0;
      core_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rdy", byte_rdy, 1);
      check_eq("rst_blk_v", blk_v, 0);
      check_eq("rst_first", blk_first, 0);
      check_eq("rst_last", blk_last, 0);
      check_eq("rst_data", M256_out, 0);
      reset = 1'b0;

      // "abc" with a stray core_done while filling
      load_abc();
      is_abc = 1'b1;
      run_msg(1'b0, 1'b1);
      is_abc = 1'b0;

      // empty message
      msg.delete();
      run_msg(1'b1, 1'b0);

      // 55 zero bytes: length just fits
      msg.delete();
      for (int i = 0; i < 55; i++) msg.push_back(8'h00);
      run_msg(1'b0, 1'b0);

      // 56 bytes: length spills into a second block
      msg.delete();
      for (int i = 0; i < 56; i++) msg.push_back(8'(i));
      run_msg(1'b0, 1'b0);

      // 64 bytes, msg_end with the last byte
      msg.delete();
      for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
      run_msg(1'b0, 1'b0);

      // 64 bytes, msg_end alone after the block
      msg.delete();
      for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
      run_msg(1'b1, 1'b0);

      // 70 bytes: byte 65 is offered while the padder waits on the core
      msg.delete();
      for (int i = 0; i < 70; i++) msg.push_back(8'($urandom));
      run_msg(1'b0, 1'b0);

      // partial message discarded by reset, then "abc" again
      for (int i = 0; i < 20; i++) send_one(1'b1, 8'($urandom), 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst2_rdy", byte_rdy, 1);
      check_eq("rst2_data", M256_out, 0);
      reset = 1'b0;
      load_abc();
      is_abc = 1'b1;
      run_msg(1'b0, 1'b0);
      is_abc = 1'b0;

      check_eq("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
